// File: rtl/ecdsa_sign_scheduler.sv
// Arbitrates NUM_REQ requesters onto one ECDSA signing engine: round-robin grant,
// launch, watchdog, zero-signature re-launch and per-owner response.
package ecdsa_sign_scheduler_pkg;
    typedef struct packed {
        logic [255:0] r;
        logic [255:0] s;
    } signature_t;
endpackage

module ecdsa_sign_scheduler
    import ecdsa_sign_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                   clk,
    input  logic                   master_reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*256-1:0] req_msg,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    output signature_t             resp_signature,
    output logic                   resp_error,
    output logic                   busy,
    output logic                   core_init,
    output logic [255:0]           core_msg,
    output logic                   core_reset,
    input  logic                   core_done,
    input  signature_t             core_signature
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_CHECK   = 3'd3,
        S_RESPOND = 3'd4,
        S_ABORT   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] r_owner;
    logic [255:0]     r_msg;
    signature_t       r_sig;
    logic             r_error;
    logic [RTY_W-1:0] r_retry_cnt;
    logic [TMR_W-1:0] r_timer;

    logic             w_found;
    logic             w_accept;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W-1:0] w_cand;
    int               w_sum;
    logic [255:0]     w_msg_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_msg
        assign w_msg_arr[g] = req_msg[256*g +: 256];
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = 0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum  = int'(r_last_grant) + k;
            w_cand = (w_sum >= NUM_REQ) ? IDX_W'(w_sum - NUM_REQ) : IDX_W'(w_sum);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_accept     = 1'b1;
                    w_next_state = S_LAUNCH;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LAUNCH: w_next_state = S_WAIT;
            S_WAIT: begin
                if (core_done) begin
                    w_next_state = S_CHECK;
                end else if (r_timer == TMR_LAST) begin
                    w_next_state = S_ABORT;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_CHECK: begin
                if (r_sig != '0) begin
                    w_next_state = S_RESPOND;
                end else if (r_retry_cnt < RTY_MAX) begin
                    w_next_state = S_LAUNCH;
                end else begin
                    w_next_state = S_ABORT;
                end
            end
            S_ABORT:   w_next_state = S_RESPOND;
            S_RESPOND: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge master_reset_n) begin
        if (!master_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Job context: owner, hash, watchdog, retries and captured result
    always_ff @(posedge clk or negedge master_reset_n) begin
        if (!master_reset_n) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_owner      <= '0;
            r_msg        <= '0;
            r_sig        <= '0;
            r_error      <= 1'b0;
            r_retry_cnt  <= '0;
            r_timer      <= '0;
        end else begin
            if (w_accept) begin
                r_msg        <= w_msg_arr[w_win];
                r_owner      <= w_win;
                r_last_grant <= w_win;
                r_error      <= 1'b0;
                r_sig        <= '0;
            end
            case (r_state)
                S_LAUNCH: r_timer <= '0;
                S_WAIT: begin
                    if (r_timer != TMR_MAX) begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                    if (core_done) begin
                        r_sig <= core_signature;
                    end
                end
                S_CHECK: begin
                    if (r_sig == '0 && r_retry_cnt < RTY_MAX) begin
                        r_retry_cnt <= r_retry_cnt + RTY_W'(1);
                    end
                end
                S_ABORT: begin
                    r_error <= 1'b1;
                    r_sig   <= '0;
                end
                S_RESPOND: r_retry_cnt <= '0;
                default: r_timer <= r_timer;
            endcase
        end
    end

    // Outputs decoded from state; accept-cycle terms are gated so reset forces zero
    always_comb begin
        req_ready = '0;
        if (master_reset_n && w_accept) begin
            req_ready[w_win] = 1'b1;
        end else begin
            req_ready = '0;
        end
        resp_valid = '0;
        if (r_state == S_RESPOND) begin
            resp_valid[r_owner] = 1'b1;
        end else begin
            resp_valid = '0;
        end
        resp_signature = (r_state == S_RESPOND && !r_error) ? r_sig : '0;
        resp_error     = (r_state == S_RESPOND) && r_error;
        busy           = (r_state != S_IDLE) || (master_reset_n && w_accept);
        core_init      = (r_state == S_LAUNCH);
        core_reset     = (r_state == S_ABORT);
        core_msg       = r_msg;
    end
endmodule
